reg_scan_checker: RTL

REG_SCAN_CHECKER -- requirements
Module: reg_scan_checker

---
 rtl/reg_check_pkg.sv | 26 ++
 rtl/cycle_counter.sv | 28 ++
 rtl/reg_scan_checker.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/reg_check_pkg.sv
// Shared types for the register scan checker: FSM encoding and the result record.
// Result fields are sized for the widest supported instance; the top slices them down.
package reg_check_pkg;

  localparam int MaxAddrBits  = 8;
  localparam int MaxDataWidth = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_HALT,
    ST_SETTLE,
    ST_COMPARE,
    ST_FINISH
  } state_e;

  typedef struct packed {
    logic                    pass;
    logic                    timeout;
    logic [MaxAddrBits:0]    mcount;
    logic [MaxAddrBits-1:0]  ff_idx;
    logic [MaxDataWidth-1:0] ff_value;
  } check_result_t;

  localparam logic [MaxAddrBits:0] CntOne = 1;

endpackage

// File: rtl/cycle_counter.sv
// Loadable saturating down-counter; used for both the settle delay and the halt timeout.
module cycle_counter #(
  parameter int Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)                       count_d = load_val_i;
    else if (dec_i && count_q != '0)  count_d = count_q - Width'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/reg_scan_checker.sv
// Walks the processor debug register port after HALT and compares each register
// against an expected image, reporting pass/timeout, mismatch count and first failure.
module reg_scan_checker
  import reg_check_pkg::*;
#(
  parameter int RegAddrBits   = 3,
  parameter int DataWidth     = 16,
  parameter int TotalReg      = 8,
  parameter int SettleCycles  = 1,
  parameter int TimeoutCycles = 64
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          start,
  input  logic                          halted,
  input  logic [TotalReg*DataWidth-1:0] expected,
  input  logic [TotalReg-1:0]           check_mask,
  output logic [RegAddrBits-1:0]        inr,
  input  logic [DataWidth-1:0]          out_value,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          timeout,
  output logic [RegAddrBits:0]          mismatch_count,
  output logic [RegAddrBits-1:0]        first_fail_idx,
  output logic [DataWidth-1:0]          first_fail_value
);

  localparam logic [RegAddrBits-1:0] LastIdx = RegAddrBits'(TotalReg - 1);

  state_e                 state_q, state_d;
  logic [RegAddrBits-1:0] inr_q, inr_d;
  check_result_t          res_q, res_d;
  logic                   done_q;

  logic        tmo_load, tmo_dec, set_load, set_dec;
  logic [15:0] tmo_cnt;
  logic [3:0]  set_cnt;
  logic [DataWidth-1:0] sel_exp;
  logic                 reg_bad;

  cycle_counter #(.Width(4)) u_settle (
    .clk_i(CLK), .rst_ni(RST_N), .load_i(set_load),
    .load_val_i(4'(SettleCycles)), .dec_i(set_dec), .count_o(set_cnt)
  );

  cycle_counter #(.Width(16)) u_timeout (
    .clk_i(CLK), .rst_ni(RST_N), .load_i(tmo_load),
    .load_val_i(16'(TimeoutCycles)), .dec_i(tmo_dec), .count_o(tmo_cnt)
  );

  assign sel_exp = expected[int'(inr_q)*DataWidth +: DataWidth];
  // Masked-off registers never count as a failure.
  assign reg_bad = check_mask[inr_q] && (out_value != sel_exp);

  always_comb begin
    state_d  = state_q;
    inr_d    = inr_q;
    res_d    = res_q;
    tmo_load = 1'b0;
    tmo_dec  = 1'b0;
    set_load = 1'b0;
    set_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          res_d    = '0;
          inr_d    = '0;
          tmo_load = 1'b1;
          state_d  = ST_WAIT_HALT;
        end
      end
      ST_WAIT_HALT: begin
        if (halted) begin
          set_load = 1'b1;
          state_d  = ST_SETTLE;
        end else if (tmo_cnt <= 16'd1) begin
          res_d.timeout = 1'b1;
          res_d.pass    = 1'b0;
          state_d       = ST_FINISH;
        end else begin
          tmo_dec = 1'b1;
        end
      end
      ST_SETTLE: begin
        set_dec = 1'b1;
        if (set_cnt <= 4'd1) state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (reg_bad) begin
          res_d.mcount = res_q.mcount + CntOne;
          if (res_q.mcount == '0) begin
            res_d.ff_idx   = MaxAddrBits'(inr_q);
            res_d.ff_value = MaxDataWidth'(out_value);
          end
        end
        if (inr_q == LastIdx) begin
          state_d = ST_FINISH;
        end else begin
          inr_d    = inr_q + RegAddrBits'(1);
          set_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_FINISH: begin
        res_d.pass = (res_q.mcount == '0) && !res_q.timeout;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      inr_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inr_q   <= inr_d;
      res_q   <= res_d;
      done_q  <= (state_q == ST_FINISH);
    end
  end

  // Upper bits of the shared result record are unused for narrow instances.
  logic unused_res;
  assign unused_res = ^res_q;

  assign inr              = inr_q;
  assign busy             = (state_q != ST_IDLE);
  assign done             = done_q;
  assign pass             = res_q.pass;
  assign timeout          = res_q.timeout;
  assign mismatch_count   = res_q.mcount[RegAddrBits:0];
  assign first_fail_idx   = res_q.ff_idx[RegAddrBits-1:0];
  assign first_fail_value = res_q.ff_value[DataWidth-1:0];

endmodule
